// File: rtl/lsu_dat_sequencer.sv
// Load/store data sequencer: turns one core access into one or two aligned
// memory beats, then returns the assembled, sign/zero-extended load result.
module lsu_dat_sequencer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [2:0]          i_req_funct3,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_strb,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [2:0] {IDLE, CMD0, WAIT0, CMD1, WAIT1, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d, split_q, split_d, err_q, err_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, beat0_q, beat0_d, beat1_q, beat1_d;

    // Request decode at accept time
    logic [OFF_W-1:0] req_off;
    logic [3:0]       req_n;
    logic             req_split, req_illegal;
    assign req_off     = i_req_addr[OFF_W-1:0];
    assign req_n       = 4'd1 << i_req_funct3[1:0];
    assign req_split   = (int'(req_off) + int'(req_n)) > NB;
    assign req_illegal = (i_req_funct3[1:0] == 2'b11) && (DATA_W == 32);

    // Datapath from registered request
    logic [OFF_W-1:0]    off_q;
    logic [3:0]          n_q;
    logic [2*NB-1:0]     lane_en;
    logic [DATA_W-1:0]   wdata_m, rsh, rdata_ext;
    logic [2*DATA_W-1:0] wcat;
    logic [ADDR_W-1:0]   addr_al;
    logic                sign;

    assign off_q   = addr_q[OFF_W-1:0];
    assign n_q     = 4'd1 << f3_q[1:0];
    assign addr_al = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign wcat    = {{DATA_W{1'b0}}, wdata_m} << {off_q, 3'b000};
    assign rsh     = DATA_W'({beat1_q, beat0_q} >> {off_q, 3'b000});

    always_comb begin
        lane_en   = '0;
        wdata_m   = '0;
        rdata_ext = '0;
        sign      = 1'b0;
        for (int i = 0; i < 2*NB; i++)
            lane_en[i] = (i >= int'(off_q)) && (i < int'(off_q) + int'(n_q));
        for (int i = 0; i < NB; i++) begin
            if (i < int'(n_q)) wdata_m[8*i +: 8] = wdata_q[8*i +: 8];
            if (i == int'(n_q) - 1) sign = rsh[8*i+7];
        end
        for (int i = 0; i < NB; i++)
            if (i < int'(n_q)) rdata_ext[8*i +: 8] = rsh[8*i +: 8];
            else               rdata_ext[8*i +: 8] = f3_q[2] ? 8'h00 : {8{sign}};
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        split_d = split_q;
        err_d   = err_q;
        beat0_d = beat0_q;
        beat1_d = beat1_q;
        unique case (state_q)
            IDLE: if (i_req_valid) begin
                we_d    = i_req_we;
                f3_d    = i_req_funct3;
                addr_d  = i_req_addr;
                wdata_d = i_req_wdata;
                split_d = req_split;
                err_d   = req_illegal || (req_split && !MISALIGN_EN);
                state_d = err_d ? RESP : CMD0;
            end
            CMD0:  if (i_mem_ready) state_d = WAIT0;
            WAIT0: if (i_mem_rvalid) begin
                beat0_d = i_mem_rdata;
                state_d = split_q ? CMD1 : RESP;
            end
            CMD1:  if (i_mem_ready) state_d = WAIT1;
            WAIT1: if (i_mem_rvalid) begin
                beat1_d = i_mem_rdata;
                state_d = RESP;
            end
            RESP:  if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            beat0_q <= '0;
            beat1_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            split_q <= split_d;
            err_q   <= err_d;
            beat0_q <= beat0_d;
            beat1_q <= beat1_d;
        end
    end

    // Outputs decode from state only, so they are zero outside their phase
    always_comb begin
        o_req_ready = (state_q == IDLE);
        o_mem_valid = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_strb  = '0;
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        o_rsp_rdata = '0;
        if (state_q == CMD0) begin
            o_mem_valid = 1'b1;
            o_mem_we    = we_q;
            o_mem_addr  = addr_al;
            o_mem_wdata = wcat[DATA_W-1:0];
            o_mem_strb  = lane_en[NB-1:0] & {NB{we_q}};
        end else if (state_q == CMD1) begin
            o_mem_valid = 1'b1;
            o_mem_we    = we_q;
            o_mem_addr  = addr_al + ADDR_W'(NB);
            o_mem_wdata = wcat[2*DATA_W-1:DATA_W];
            o_mem_strb  = lane_en[2*NB-1:NB] & {NB{we_q}};
        end else if (state_q == RESP) begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = err_q;
            o_rsp_rdata = (we_q || err_q) ? '0 : rdata_ext;
        end
    end
endmodule

// File: tb/tb_lsu_dat_sequencer.sv
// Bench for lsu_dat_sequencer (DATA_W=32): directed table, split/reset corner
// sequences, and randomized accesses against a byte-level reference model.
module tb_lsu_dat_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 0, req_valid0 = 0, req_we = 0, rsp_ready = 0;
    logic        mem_ready = 0, mem_rvalid = 0;
    logic [2:0]  req_f3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;

    logic        req_ready, rsp_valid, rsp_err, mem_valid, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_strb;
    logic        req_ready0, rsp_valid0, rsp_err0, mem_valid0, mem_we0;
    logic [31:0] rsp_rdata0, mem_addr0, mem_wdata0;
    logic [3:0]  mem_strb0;

    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    lsu_dat_sequencer #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_strb(mem_strb), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata));

    lsu_dat_sequencer #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid0), .o_req_ready(req_ready0),
        .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata0), .o_rsp_err(rsp_err0),
        .o_mem_valid(mem_valid0), .i_mem_ready(mem_ready), .o_mem_we(mem_we0), .o_mem_addr(mem_addr0),
        .o_mem_wdata(mem_wdata0), .o_mem_strb(mem_strb0), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-level model: byte k of the access lives at position off+k of a
    // two-beat window; beat = position / 4, lane = position % 4.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, m0, m1, input bit mis_en,
                                  output int nbeat, output logic [1:0][31:0] ea,
                                  output logic [1:0][3:0] es, output logic [1:0][31:0] ew,
                                  output logic [31:0] rd, output logic er);
        int n, off, p;
        logic sgn;
        n   = 1 << f3[1:0];
        off = int'(addr[1:0]);
        er  = (f3[1:0] == 2'b11) || (!mis_en && off + n > 4);
        nbeat = er ? 0 : ((off + n > 4) ? 2 : 1);
        ea[0] = addr - 32'(off);
        ea[1] = addr - 32'(off) + 32'd4;
        es = '0; ew = '0; rd = '0;
        if (!er) begin
            for (int k = 0; k < n; k++) begin
                p = off + k;
                rd[8*k +: 8] = (p < 4) ? m0[8*(p%4) +: 8] : m1[8*(p%4) +: 8];
                if (we) begin
                    es[p/4][p%4] = 1'b1;
                    ew[p/4][8*(p%4) +: 8] = wd[8*k +: 8];
                end
            end
            sgn = rd[8*n-1];
            for (int k = n; k < 4; k++) rd[8*k +: 8] = f3[2] ? 8'h00 : {8{sgn}};
        end
        if (we || er) rd = '0;
    endfunction

    // One full access on u_dut, cycle-exact; every cycle's outputs are checked.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, m0, m1, output logic [31:0] rd, output logic er);
        int nbeat, lat;
        logic [1:0][31:0] ea, ew;
        logic [1:0][3:0]  es;
        logic [31:0] erd, wm;
        logic eer;
        model(we, f3, addr, wd, m0, m1, 1'b1, nbeat, ea, es, ew, erd, eer);
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 0; req_we = 1'($urandom); req_f3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
        for (int b = 0; b < nbeat; b++) begin
            lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
                chk("mem_valid", {31'b0, mem_valid}, 32'd1);
                chk("mem_addr", mem_addr, ea[b]);
                chk("mem_strb", {28'b0, mem_strb}, {28'b0, es[b]});
                chk("mem_we", {31'b0, mem_we}, {31'b0, we});
                if (we) begin
                    for (int i = 0; i < 4; i++) wm[8*i +: 8] = {8{es[b][i]}};
                    chk("mem_wdata", mem_wdata & wm, ew[b] & wm);
                end
                mem_ready  = (c == lat);
                mem_rvalid = 1'($urandom);   // never a completion while in CMD
                mem_rdata  = $urandom;
                @(negedge clk);
            end
            mem_ready = 0; mem_rvalid = 0;
            lat = $urandom_range(0, 2);
            repeat (lat) begin
                chk("wait_mem_valid", {31'b0, mem_valid}, 32'd0);
                @(negedge clk);
            end
            mem_rvalid = 1; mem_rdata = (b == 0) ? m0 : m1;
            @(negedge clk);
            mem_rvalid = 0; mem_rdata = $urandom;
        end
        chk("resp_mem_valid", {31'b0, mem_valid}, 32'd0);
        rd = rsp_rdata; er = rsp_err;
        lat = $urandom_range(0, 2);
        for (int c = 0; c <= lat; c++) begin
            chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rsp_rdata", rsp_rdata, erd);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, eer});
            rsp_ready = (c == lat);
            @(negedge clk);
        end
        rsp_ready = 0;
        chk("rsp_done", {31'b0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd, m0, m1, rd;
        logic        er;
    } vec_t;
    vec_t tbl[10];

    initial begin
        logic [31:0] rd;
        logic er, we;
        logic [2:0] f3;
        logic [31:0] addr;
        tbl[0] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 32'h0,        32'h8899AABB, 1'b0};
        tbl[1] = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[2] = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 32'h0,        32'h00000080, 1'b0};
        tbl[3] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h44332211, 32'h88776655, 32'h66554433, 1'b0};
        tbl[4] = '{1'b0, 3'b001, 32'h103, 32'h0,        32'h44332211, 32'h88776655, 32'h00005544, 1'b0};
        tbl[5] = '{1'b1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0,        32'h0,        32'h00000000, 1'b0};
        tbl[6] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        32'h0,        32'h00000000, 1'b1};
        tbl[7] = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, 32'h0,        32'h000080FF, 1'b0};
        tbl[8] = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF0000, 32'h0,        32'hFFFF80FF, 1'b0};
        tbl[9] = '{1'b0, 3'b110, 32'hFFFFFFFE, 32'h0,   32'hCDAB0000, 32'h00001234, 32'h1234CDAB, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_outs", {mem_we, rsp_err, mem_strb} | mem_addr | mem_wdata | rsp_rdata, 32'd0);

        foreach (tbl[i]) begin
            txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].m0, tbl[i].m1, rd, er);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].er});
        end

        // Explicit split-store beats: SH 0x103, 0xBEEF
        @(negedge clk);
        req_valid = 1; req_we = 1; req_f3 = 3'b001; req_addr = 32'h103; req_wdata = 32'h0000BEEF;
        @(negedge clk);
        req_valid = 0;
        chk("sh_b0_addr", mem_addr, 32'h100);
        chk("sh_b0_strb", {28'b0, mem_strb}, 32'h8);
        chk("sh_b0_wdata", mem_wdata & 32'hFF000000, 32'hEF000000);
        mem_ready = 1; @(negedge clk); mem_ready = 0;
        mem_rvalid = 1; @(negedge clk); mem_rvalid = 0;
        chk("sh_b1_addr", mem_addr, 32'h104);
        chk("sh_b1_strb", {28'b0, mem_strb}, 32'h1);
        chk("sh_b1_wdata", mem_wdata & 32'h000000FF, 32'h000000BE);
        mem_ready = 1; @(negedge clk); mem_ready = 0;
        mem_rvalid = 1; @(negedge clk); mem_rvalid = 0;
        chk("sh_rsp", {30'b0, rsp_valid, rsp_err}, 32'h2);
        rsp_ready = 1; @(negedge clk); rsp_ready = 0;

        // MISALIGN_EN=0: misaligned LW rejected without a memory command
        req_valid0 = 1; req_we = 0; req_f3 = 3'b010; req_addr = 32'h101;
        @(negedge clk);
        req_valid0 = 0;
        chk("mis0_rsp", {29'b0, rsp_valid0, rsp_err0, mem_valid0}, 32'h6);
        rsp_ready = 1; @(negedge clk); rsp_ready = 0;
        chk("mis0_idle", {30'b0, req_ready0, mem_valid0}, 32'h2);
        // MISALIGN_EN=0: aligned LW with memory stalling 3 cycles
        req_valid0 = 1; req_addr = 32'h100;
        @(negedge clk);
        req_valid0 = 0; req_addr = 32'h5A5;
        repeat (3) begin
            chk("stall_valid", {31'b0, mem_valid0}, 32'd1);
            chk("stall_addr", mem_addr0, 32'h100);
            chk("stall_strbwe", {27'b0, mem_we0, mem_strb0}, 32'd0);
            @(negedge clk);
        end
        mem_ready = 1; @(negedge clk); mem_ready = 0;
        mem_rvalid = 1; mem_rdata = 32'h12345678; @(negedge clk); mem_rvalid = 0;
        chk("stall_rsp", rsp_rdata0, 32'h12345678);
        chk("stall_rsp_v", {30'b0, rsp_valid0, rsp_err0}, 32'h2);
        rsp_ready = 1; @(negedge clk); rsp_ready = 0;

        // Reset during WAIT1, then a stray completion
        req_valid = 1; req_we = 0; req_f3 = 3'b010; req_addr = 32'h102;
        @(negedge clk); req_valid = 0;
        mem_ready = 1; @(negedge clk); mem_ready = 0;
        mem_rvalid = 1; mem_rdata = 32'h44332211; @(negedge clk); mem_rvalid = 0;
        mem_ready = 1; @(negedge clk); mem_ready = 0;
        chk("wait1_idle_bus", {30'b0, mem_valid, rsp_valid}, 32'd0);
        rst_n = 0; @(negedge clk); rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; @(negedge clk); mem_rvalid = 0;
        repeat (3) begin
            chk("postrst_ctl", {29'b0, req_ready, mem_valid, rsp_valid}, 32'h4);
            chk("postrst_outs", {mem_we, rsp_err, mem_strb} | mem_addr | mem_wdata | rsp_rdata, 32'd0);
            @(negedge clk);
        end
        txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h44332211, 32'h88776655, rd, er);
        chk("postrst_txn", rd, 32'h66554433);

        // Randomized accesses
        for (int t = 0; t < 200; t++) begin
            we   = 1'($urandom);
            f3   = 3'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
            txn(we, f3, addr, $urandom, $urandom, $urandom, rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_dat_sequencer.md
LSU_DAT_SEQUENCER -- requirements
Module: lsu_dat_sequencer

Parameters
REQ-001 DATA_W, 32, bus/data width in bits; legal values 32 or 64.
REQ-002 ADDR_W, 32, byte address width.
REQ-003 MISALIGN_EN, 1, 1 = split boundary-crossing accesses into two beats; 0 = reject them with an error.

Interface
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_rst_n  in  1  synchronous reset, active-low.
REQ-006 i_req_valid  in  1  core request valid.
REQ-007 o_req_ready  out  1  block can accept a request; high only in IDLE.
REQ-008 i_req_we  in  1  1 = store, 0 = load.
REQ-009 i_req_funct3  in  3  [1:0] size (00 B, 01 H, 10 W, 11 D; D only legal when DATA_W=64); [2] = unsigned load.
REQ-010 i_req_addr  in  ADDR_W  byte address.
REQ-011 i_req_wdata  in  DATA_W  store data, right-aligned.
REQ-012 o_rsp_valid / i_rsp_ready  out/in  1/1  response handshake.
REQ-013 o_rsp_rdata  out  DATA_W  load result, sign- or zero-extended; 0 for stores.
REQ-014 o_rsp_err  out  1  misaligned access with MISALIGN_EN=0, or illegal size.
REQ-015 o_mem_valid / i_mem_ready  out/in  1/1  memory command handshake.
REQ-016 o_mem_we, o_mem_addr[ADDR_W], o_mem_wdata[DATA_W], o_mem_strb[DATA_W/8]  out  command fields; address always DATA_W/8-aligned.
REQ-017 i_mem_rvalid, i_mem_rdata[DATA_W]  in  beat completion (reads and writes), read data.

Function
REQ-018 FSM states IDLE, CMD0, WAIT0, CMD1, WAIT1, RESP; one request outstanding at a time.
REQ-019 Request accept in IDLE on i_req_valid&o_req_ready; request fields are registered then and inputs are ignored afterwards.
REQ-020 Let off = addr mod (DATA_W/8) and n = 2^size bytes; an access is split when off+n > DATA_W/8.
REQ-021 Illegal size, or split with MISALIGN_EN=0: IDLE->RESP with o_rsp_err=1 and no memory command issued.
REQ-022 Otherwise IDLE->CMD0; o_mem_valid is high starting in the cycle after accept (1-cycle latency).
REQ-023 CMD0: o_mem_addr = aligned addr; o_mem_strb = bytes [off, min(off+n, DATA_W/8)-1]; o_mem_wdata = wdata shifted left by 8*off.
REQ-024 Command fields stay stable while o_mem_valid&!i_mem_ready; CMDx->WAITx on i_mem_ready.
REQ-025 WAIT0 on i_mem_rvalid: capture rdata, then go to CMD1 if split, else to RESP.
REQ-026 CMD1: o_mem_addr = aligned addr + DATA_W/8, wrapping modulo 2^ADDR_W; strb = low (off+n-DATA_W/8) bytes; wdata = remaining upper store bytes placed at byte 0.
REQ-027 WAIT1 on i_mem_rvalid: capture rdata, then go to RESP.
REQ-028 Load assembly: byte k of the result = byte (off+k) of the beat0/beat1 concatenation for k<n; the upper bytes are the sign of byte n-1, or 0 if funct3[2]=1.
REQ-029 RESP: o_rsp_valid=1 with stable rdata/err; RESP->IDLE on i_rsp_ready; next accept is no earlier than the following cycle.
REQ-030 i_mem_rvalid outside WAIT0/WAIT1 is ignored; i_mem_ready and i_mem_rvalid in the same cycle as CMDx count only as ready.
REQ-031 funct3[2] is ignored for stores and for D size.

Reset
REQ-032 While i_rst_n=0 at a clock edge: state=IDLE; o_req_ready=1 after release; o_mem_valid, o_rsp_valid, o_rsp_err, o_mem_we, o_mem_strb = 0; o_mem_addr, o_mem_wdata, o_rsp_rdata = 0.
REQ-033 Reset in any state aborts the access with no response; a later i_mem_rvalid for it is ignored per REQ-030.

Verification (DATA_W=32)
REQ-034 LW 0x100, mem returns 0x8899AABB -> one beat at 0x100 with strb 0000 for the read, rsp 0x8899AABB, err 0.
REQ-035 LB 0x103 with rdata 0x80112233 -> rsp 0xFFFFFF80; LBU same address and data -> rsp 0x00000080.
REQ-036 LW 0x102, beats 0x100 -> 0x44332211 and 0x104 -> 0x88776655 -> rsp 0x66554433; LH 0x103, same beats -> 0x00005544.
REQ-037 SH 0x103, wdata 0x0000BEEF -> beat0 addr 0x100 strb 1000 wdata 0xEF000000; beat1 addr 0x104 strb 0001 wdata 0x000000BE.
REQ-038 MISALIGN_EN=0, LW 0x101 -> rsp err=1 in the cycle after accept, o_mem_valid never asserted; i_mem_ready held low 3 cycles -> command fields unchanged.
REQ-039 Reset asserted in WAIT1, stray i_mem_rvalid after release -> no o_rsp_valid, all outputs at reset values, and next request handled correctly.
